// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : FunSel codes, flag bit indices and shifter op encoding shared
//            by the ALU stage and its shifter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [4:0] FS_PASS_A = 5'b00000;
    localparam logic [4:0] FS_PASS_B = 5'b00001;
    localparam logic [4:0] FS_NOT_A  = 5'b00010;
    localparam logic [4:0] FS_NOT_B  = 5'b00011;
    localparam logic [4:0] FS_ADD    = 5'b00100;
    localparam logic [4:0] FS_ADC    = 5'b00101;
    localparam logic [4:0] FS_SUB    = 5'b00110;
    localparam logic [4:0] FS_AND    = 5'b00111;
    localparam logic [4:0] FS_OR     = 5'b01000;
    localparam logic [4:0] FS_XOR    = 5'b01001;
    localparam logic [4:0] FS_NAND   = 5'b01010;
    localparam logic [4:0] FS_LSL    = 5'b01011;
    localparam logic [4:0] FS_LSR    = 5'b01100;
    localparam logic [4:0] FS_ASR    = 5'b01101;
    localparam logic [4:0] FS_CSL    = 5'b01110;
    localparam logic [4:0] FS_CSR    = 5'b01111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        SHIFT_LSL = 3'd0,
        SHIFT_LSR = 3'd1,
        SHIFT_ASR = 3'd2,
        SHIFT_CSL = 3'd3,
        SHIFT_CSR = 3'd4
    } shift_op_t;

endpackage
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_shifter
// Purpose  : One-bit shift/rotate of operand A; rotates go through the
//            stored carry, and the bit pushed out is reported for the C flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_cf,
    input  shift_op_t        i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_shift_out
);

    always_comb begin
        o_result    = i_a;
        o_shift_out = i_a[0];
        case (i_op)
            SHIFT_LSL: begin
                o_result    = {i_a[WIDTH-2:0], 1'b0};
                o_shift_out = i_a[WIDTH-1];
            end
            SHIFT_LSR: begin
                o_result    = {1'b0, i_a[WIDTH-1:1]};
                o_shift_out = i_a[0];
            end
            SHIFT_ASR: begin
                o_result    = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
                o_shift_out = i_a[0];
            end
            SHIFT_CSL: begin
                o_result    = {i_a[WIDTH-2:0], i_cf};
                o_shift_out = i_a[WIDTH-1];
            end
            SHIFT_CSR: begin
                o_result    = {i_cf, i_a[WIDTH-1:1]};
                o_shift_out = i_a[0];
            end
            default: begin
                o_result    = i_a;
                o_shift_out = i_a[0];
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_unit
// Purpose  : 16-bit ALU with combinational result and a {Z,C,N,O} flag
//            register. Define ALU_ROTATE_EN to enable CSL/CSR (01110/01111);
//            otherwise those codes act as reserved.
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);

    logic [3:0]       r_flags;
    logic             w_cf;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH:0]   w_sum;
    shift_op_t        w_shift_op;
    logic [WIDTH-1:0] w_shift_res;
    logic             w_shift_out;
    logic [WIDTH-1:0] w_result;
    logic             w_valid;
    logic             w_upd_n;
    logic             w_upd_c;
    logic             w_upd_o;
    logic             w_c_new;
    logic             w_o_new;
    logic [3:0]       w_flags_next;

    assign w_cf = r_flags[FLAG_C];

    // One adder serves ADD, ADC and SUB (A + ~B + 1).
    always_comb begin
        w_add_b   = B;
        w_add_cin = 1'b0;
        if (FunSel == FS_SUB) begin
            w_add_b   = ~B;
            w_add_cin = 1'b1;
        end else if (FunSel == FS_ADC) begin
            w_add_cin = w_cf;
        end
    end

    assign w_sum = {1'b0, A} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};

    always_comb begin
        case (FunSel)
            FS_LSR:  w_shift_op = SHIFT_LSR;
            FS_ASR:  w_shift_op = SHIFT_ASR;
`ifdef ALU_ROTATE_EN
            FS_CSL:  w_shift_op = SHIFT_CSL;
            FS_CSR:  w_shift_op = SHIFT_CSR;
`endif
            default: w_shift_op = SHIFT_LSL;
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .i_a         (A),
        .i_cf        (w_cf),
        .i_op        (w_shift_op),
        .o_result    (w_shift_res),
        .o_shift_out (w_shift_out)
    );

    always_comb begin
        w_result = A;
        w_valid  = 1'b1;
        w_upd_n  = 1'b1;
        w_upd_c  = 1'b0;
        w_upd_o  = 1'b0;
        w_c_new  = w_cf;
        w_o_new  = r_flags[FLAG_O];
        case (FunSel)
            FS_PASS_A: w_result = A;
            FS_PASS_B: w_result = B;
            FS_NOT_A:  w_result = ~A;
            FS_NOT_B:  w_result = ~B;
            FS_ADD, FS_ADC: begin
                w_result = w_sum[WIDTH-1:0];
                w_upd_c  = 1'b1;
                w_c_new  = w_sum[WIDTH];
                w_upd_o  = 1'b1;
                w_o_new  = (A[WIDTH-1] == B[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            FS_SUB: begin
                w_result = w_sum[WIDTH-1:0];
                w_upd_c  = 1'b1;
                w_c_new  = w_sum[WIDTH];
                w_upd_o  = 1'b1;
                w_o_new  = (A[WIDTH-1] != B[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            FS_AND:    w_result = A & B;
            FS_OR:     w_result = A | B;
            FS_XOR:    w_result = A ^ B;
            FS_NAND:   w_result = ~(A & B);
            FS_LSL, FS_LSR: begin
                w_result = w_shift_res;
                w_upd_c  = 1'b1;
                w_c_new  = w_shift_out;
            end
            FS_ASR: begin
                w_result = w_shift_res;
                w_upd_c  = 1'b1;
                w_c_new  = w_shift_out;
                w_upd_n  = 1'b0;
            end
`ifdef ALU_ROTATE_EN
            FS_CSL, FS_CSR: begin
                w_result = w_shift_res;
                w_upd_c  = 1'b1;
                w_c_new  = w_shift_out;
            end
`endif
            default: begin
                w_result = A;
                w_valid  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_flags_next         = r_flags;
        w_flags_next[FLAG_Z] = (w_result == '0);
        if (w_upd_n) w_flags_next[FLAG_N] = w_result[WIDTH-1];
        if (w_upd_c) w_flags_next[FLAG_C] = w_c_new;
        if (w_upd_o) w_flags_next[FLAG_O] = w_o_new;
    end

    // Reserved codes never write flags, even with WF asserted.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_flags <= 4'b0000;
        end else if (WF && w_valid) begin
            r_flags <= w_flags_next;
        end
    end

    assign ALUOut   = w_result;
    assign FlagsOut = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_flag_unit
// Purpose  : Directed vector bench for alu_flag_unit (result and flag history).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_unit;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  fs;
        logic        wf;
        logic [15:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  fs;
    logic        wf;
    logic [15:0] alu_out;
    logic [3:0]  flags;

    int n_total;
    int n_pass;
    vec_t vecs[$];

    alu_flag_unit #(.WIDTH(16)) dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .A        (a),
        .B        (b),
        .FunSel   (fs),
        .WF       (wf),
        .ALUOut   (alu_out),
        .FlagsOut (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        a = 16'h0; b = 16'h0; fs = 5'b00000; wf = 1'b0;

        // Reset state, then load non-zero flags (8000 - 1 -> 0101).
        @(negedge clk);
        check("reset flags", {12'h0, flags}, 16'h0000);
        rst_n = 1'b1;
        a = 16'h8000; b = 16'h0001; fs = 5'b00110; wf = 1'b1;
        @(posedge clk); #1;
        check("pre-reset flags", {12'h0, flags}, 16'h0005);

        // Asynchronous clear, no clock edge in between.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async clear", {12'h0, flags}, 16'h0000);

        // WF=1 edge while reset is low must be ignored.
        a = 16'h7FFF; b = 16'h0001; fs = 5'b00100; wf = 1'b1;
        @(posedge clk); #1;
        check("wf during reset", {12'h0, flags}, 16'h0000);

        // First load after release: 0 + 0 -> Z only.
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'h0000; b = 16'h0000; fs = 5'b00100; wf = 1'b1;
        @(posedge clk); #1;
        check("first load", {12'h0, flags}, 16'h0008);

        // Flag history carries from row to row.
        vecs.push_back('{16'hFFFF, 16'h0001, 5'b00100, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'h0001, 16'h0000, 5'b00101, 1'b1, 16'h0002, 4'b0000});
        vecs.push_back('{16'h7FFF, 16'h0001, 5'b00100, 1'b1, 16'h8000, 4'b0011});
        vecs.push_back('{16'h8000, 16'h0001, 5'b00110, 1'b1, 16'h7FFF, 4'b0101});
        vecs.push_back('{16'h0000, 16'h1234, 5'b00000, 1'b1, 16'h0000, 4'b1101});
        vecs.push_back('{16'h0000, 16'h8000, 5'b00001, 1'b1, 16'h8000, 4'b0111});
        vecs.push_back('{16'hFFFF, 16'h0000, 5'b00010, 1'b1, 16'h0000, 4'b1101});
        vecs.push_back('{16'h0000, 16'h00FF, 5'b00011, 1'b1, 16'hFF00, 4'b0111});
        vecs.push_back('{16'h00F0, 16'h0F00, 5'b00111, 1'b0, 16'h0000, 4'b0111});
        vecs.push_back('{16'h00F0, 16'h0F00, 5'b01000, 1'b1, 16'h0FF0, 4'b0101});
        vecs.push_back('{16'hFFFF, 16'h0F0F, 5'b01001, 1'b1, 16'hF0F0, 4'b0111});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 5'b01010, 1'b1, 16'h0000, 4'b1101});
        vecs.push_back('{16'h8001, 16'h0000, 5'b01011, 1'b1, 16'h0002, 4'b0101});
        vecs.push_back('{16'h0002, 16'h0000, 5'b01100, 1'b1, 16'h0001, 4'b0001});
        vecs.push_back('{16'h1234, 16'h0000, 5'b10110, 1'b1, 16'h1234, 4'b0001});
        vecs.push_back('{16'h8000, 16'h0000, 5'b01101, 1'b1, 16'hC000, 4'b0001});
        vecs.push_back('{16'h0001, 16'h0000, 5'b01101, 1'b1, 16'h0000, 4'b1101});
        vecs.push_back('{16'h0001, 16'h0002, 5'b00110, 1'b1, 16'hFFFF, 4'b0010});
        vecs.push_back('{16'hFFFF, 16'h0000, 5'b00101, 1'b1, 16'hFFFF, 4'b0010});
        vecs.push_back('{16'h8000, 16'h8000, 5'b00100, 1'b1, 16'h0000, 4'b1101});
        vecs.push_back('{16'h0000, 16'h0000, 5'b00101, 1'b1, 16'h0001, 4'b0000});
        vecs.push_back('{16'h8000, 16'h0000, 5'b01011, 1'b1, 16'h0000, 4'b1100});
`ifdef ALU_ROTATE_EN
        vecs.push_back('{16'h8001, 16'h0000, 5'b01111, 1'b1, 16'hC000, 4'b0110});
        vecs.push_back('{16'h4000, 16'h0000, 5'b01110, 1'b1, 16'h8001, 4'b0010});
`else
        vecs.push_back('{16'h8001, 16'h0000, 5'b01111, 1'b1, 16'h8001, 4'b1100});
        vecs.push_back('{16'h4000, 16'h0000, 5'b01110, 1'b1, 16'h4000, 4'b1100});
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            a  = vecs[i].a;
            b  = vecs[i].b;
            fs = vecs[i].fs;
            wf = vecs[i].wf;
            #1;
            check($sformatf("vec%0d ALUOut", i), alu_out, vecs[i].exp_out);
            @(posedge clk); #1;
            check($sformatf("vec%0d FlagsOut", i), {12'h0, flags}, {12'h0, vecs[i].exp_flags});
        end

        // WF=0 holds the flags across several edges while the inputs change.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; fs = 5'b00100; wf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ALU_ROTATE_EN
        check("wf0 hold", {12'h0, flags}, 16'h0002);
`else
        check("wf0 hold", {12'h0, flags}, 16'h000C);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
